// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage and its opcode encoder.
package alu_pkg;

   localparam int DW = 16;
   localparam int RW = 3;

   typedef enum logic [2:0] {
      ALU_ADD     = 3'd0,
      ALU_SUB     = 3'd1,
      ALU_AND     = 3'd2,
      ALU_OR      = 3'd3,
      ALU_NOR     = 3'd4,
      ALU_XOR     = 3'd5,
      ALU_ILLEGAL = 3'd6
   } alu_op_e;

   localparam logic [2:0] OP_ARITH = 3'b100;
   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_NOR   = 3'b010;
   localparam logic [2:0] OP_XOR   = 3'b011;

   // One held instruction, already encoded for the ALU.
   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [2:0]    operation;
      logic          binvert;
      logic          carryin;
      logic [RW-1:0] rd;
      logic          reg_write;
      logic          illegal;
   } slot_t;

   localparam slot_t SLOT_RST = '{
      a:         {DW{1'b0}},
      b:         {DW{1'b0}},
      operation: OP_ARITH,
      binvert:   1'b1,
      carryin:   1'b0,
      rd:        {RW{1'b0}},
      reg_write: 1'b0,
      illegal:   1'b0
   };

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-side and EX-side handshake bundles of the ALU issue stage.
interface alu_dec_if;
   logic                     dec_valid;
   logic                     dec_ready;
   logic [2:0]               dec_alu_op;
   logic [alu_pkg::DW-1:0]   dec_rs_val;
   logic [alu_pkg::DW-1:0]   dec_rt_val;
   logic [alu_pkg::DW-1:0]   dec_imm;
   logic                     dec_use_imm;
   logic [alu_pkg::RW-1:0]   dec_rs;
   logic [alu_pkg::RW-1:0]   dec_rt;
   logic [alu_pkg::RW-1:0]   dec_rd;
   logic                     dec_reg_write;

   modport master (
      output dec_valid, dec_alu_op, dec_rs_val, dec_rt_val, dec_imm, dec_use_imm,
             dec_rs, dec_rt, dec_rd, dec_reg_write,
      input  dec_ready
   );
   modport slave (
      input  dec_valid, dec_alu_op, dec_rs_val, dec_rt_val, dec_imm, dec_use_imm,
             dec_rs, dec_rt, dec_rd, dec_reg_write,
      output dec_ready
   );
endinterface

interface alu_ex_if;
   logic                     ex_valid;
   logic                     ex_ready;
   logic [alu_pkg::DW-1:0]   A;
   logic [alu_pkg::DW-1:0]   B;
   logic [2:0]               operation;
   logic                     Binvert;
   logic                     carryin;
   logic [alu_pkg::RW-1:0]   ex_rd;
   logic                     ex_reg_write;
   logic                     ex_illegal;

   modport master (
      output ex_valid, A, B, operation, Binvert, carryin, ex_rd, ex_reg_write, ex_illegal,
      input  ex_ready
   );
   modport slave (
      input  ex_valid, A, B, operation, Binvert, carryin, ex_rd, ex_reg_write, ex_illegal,
      output ex_ready
   );
endinterface

// File: rtl/alu_ctrl_enc.sv
// Combinational abstract-opcode to ALU operation/Binvert/carryin encoder.
module alu_ctrl_enc
   import alu_pkg::*;
(
   input  logic [2:0] op_i,
   output logic [2:0] operation_o,
   output logic       binvert_o,
   output logic       carryin_o,
   output logic       illegal_o
);

   // Opcode decode; unknown codes fall back to ADD and are flagged.
   always_comb begin
      operation_o = OP_ARITH;
      binvert_o   = 1'b1;
      carryin_o   = 1'b0;
      illegal_o   = 1'b0;
      case (op_i)
         ALU_ADD: operation_o = OP_ARITH;
         ALU_SUB: begin
            binvert_o = 1'b0;
            carryin_o = 1'b1;
         end
         ALU_AND: operation_o = OP_AND;
         ALU_OR:  operation_o = OP_OR;
         ALU_NOR: operation_o = OP_NOR;
         ALU_XOR: operation_o = OP_XOR;
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: encodes on entry and holds results in an output slot plus skid slot.
// Optional operand forwarding is built when macro FORWARD_EN is defined.
module alu_issue_stage
   import alu_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   alu_dec_if.slave      dec,
   alu_ex_if.master      ex,
   input  logic          fwd_valid_i,
   input  logic [RW-1:0] fwd_rd_i,
   input  logic [DW-1:0] fwd_data_i
);

   slot_t      entry_s;
   slot_t      out_q, out_d;
   slot_t      skid_q, skid_d;
   logic       out_vld_q, out_vld_d;
   logic       skid_vld_q, skid_vld_d;
   logic       dec_ready_q, dec_ready_d;
   logic [2:0] enc_op_s;
   logic       enc_binv_s, enc_cin_s, enc_ill_s;
   logic       accept_s, drain_s, load_out_s;

   alu_ctrl_enc u_enc (
      .op_i        (dec.dec_alu_op),
      .operation_o (enc_op_s),
      .binvert_o   (enc_binv_s),
      .carryin_o   (enc_cin_s),
      .illegal_o   (enc_ill_s)
   );

   // Build the encoded slot image of the instruction offered by decode.
   always_comb begin
      entry_s           = SLOT_RST;
      entry_s.a         = dec.dec_rs_val;
      entry_s.b         = dec.dec_use_imm ? dec.dec_imm : dec.dec_rt_val;
`ifdef FORWARD_EN
      if (fwd_valid_i && (fwd_rd_i != {RW{1'b0}}) && (fwd_rd_i == dec.dec_rs)) begin
         entry_s.a = fwd_data_i;
      end else begin
         entry_s.a = dec.dec_rs_val;
      end
      if (fwd_valid_i && (fwd_rd_i != {RW{1'b0}}) && !dec.dec_use_imm
          && (fwd_rd_i == dec.dec_rt)) begin
         entry_s.b = fwd_data_i;
      end else begin
         entry_s.b = dec.dec_use_imm ? dec.dec_imm : dec.dec_rt_val;
      end
`endif
      entry_s.operation = enc_op_s;
      entry_s.binvert   = enc_binv_s;
      entry_s.carryin   = enc_cin_s;
      entry_s.rd        = dec.dec_rd;
      entry_s.reg_write = dec.dec_reg_write & ~enc_ill_s;
      entry_s.illegal   = enc_ill_s;
   end

`ifndef FORWARD_EN
   logic unused_fwd_s;
   assign unused_fwd_s = ^{fwd_valid_i, fwd_rd_i, fwd_data_i, dec.dec_rs, dec.dec_rt};
`endif

   assign accept_s   = dec.dec_valid & dec_ready_q;
   assign drain_s    = out_vld_q & ex.ex_ready;
   assign load_out_s = ~out_vld_q | drain_s;

   // Slot next-state: flush wins, otherwise skid drains ahead of any newer entry.
   always_comb begin
      out_d      = out_q;
      skid_d     = skid_q;
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush_i) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (load_out_s) begin
         if (skid_vld_q) begin
            out_d      = skid_q;
            out_vld_d  = 1'b1;
            skid_vld_d = accept_s;
            skid_d     = accept_s ? entry_s : skid_q;
         end else begin
            out_vld_d = accept_s;
            out_d     = accept_s ? entry_s : out_q;
         end
      end else if (accept_s) begin
         skid_d     = entry_s;
         skid_vld_d = 1'b1;
      end else begin
         skid_vld_d = skid_vld_q;
      end
      dec_ready_d = ~skid_vld_d;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_q       <= SLOT_RST;
         skid_q      <= SLOT_RST;
         out_vld_q   <= 1'b0;
         skid_vld_q  <= 1'b0;
         dec_ready_q <= 1'b1;
      end else begin
         out_q       <= out_d;
         skid_q      <= skid_d;
         out_vld_q   <= out_vld_d;
         skid_vld_q  <= skid_vld_d;
         dec_ready_q <= dec_ready_d;
      end
   end

   assign dec.dec_ready   = dec_ready_q;
   assign ex.ex_valid     = out_vld_q;
   assign ex.A            = out_q.a;
   assign ex.B            = out_q.b;
   assign ex.operation    = out_q.operation;
   assign ex.Binvert      = out_q.binvert;
   assign ex.carryin      = out_q.carryin;
   assign ex.ex_rd        = out_q.rd;
   assign ex.ex_reg_write = out_q.reg_write & out_vld_q;
   assign ex.ex_illegal   = out_q.illegal;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 16-bit ALU.
- Accepts decoded instructions from decode over a valid/ready handshake.
- Selects operand B (register or immediate) and encodes the abstract ALU opcode into the ALU's operation/Binvert/carryin control triple.
- Holds the result through a 2-entry skid buffer so decode is never combinationally stalled by downstream back-pressure.

Parameters:
- DW, 16, operand/data width
- RW, 3, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  kill all held instructions (branch redirect)
- dec_valid  in  1  decode offers an instruction
- dec_ready  out  1  stage can accept; registered
- dec_alu_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6–7 illegal
- dec_rs_val  in  DW  source register value
- dec_rt_val  in  DW  second register value
- dec_imm  in  DW  pre-extended immediate
- dec_use_imm  in  1  1: B = imm, 0: B = rt
- dec_rs  in  RW  rs index (used for forwarding)
- dec_rt  in  RW  rt index (used for forwarding)
- dec_rd  in  RW  destination index
- dec_reg_write  in  1  destination write enable
- ex_ready  in  1  EX/MEM consumer accepts
- ex_valid  out  1  outputs below are valid
- A  out  DW  ALU operand A
- B  out  DW  ALU operand B
- operation  out  3  ALU operation code
- Binvert  out  1  ALU control
- carryin  out  1  ALU control
- ex_rd  out  RW  destination index
- ex_reg_write  out  1  write enable; 0 when ex_valid = 0
- ex_illegal  out  1  opcode was 6 or 7
- fwd_valid  in  1  forward source valid (FORWARD_EN only)
- fwd_rd  in  RW  forward destination index
- fwd_data  in  DW  forward value

Behaviour:
- Opcode encoding, as operation/Binvert/carryin:
  - ADD: 100/1/0
  - SUB: 100/0/1
  - AND: 000/1/0
  - OR: 001/1/0
  - NOR: 010/1/0
  - XOR: 011/1/0
  - Illegal (6, 7): encoded as ADD with ex_illegal = 1 and ex_reg_write forced to 0.
- Encoding and operand-B mux happen on entry; both slots store already-encoded fields.
- Storage: output slot (drives outputs) and skid slot, each with its own valid bit.
- Accept occurs when dec_valid & dec_ready.
- Output slot drains when ex_valid & ex_ready.
- Output slot loads from the skid slot if it is valid, otherwise from the incoming instruction, whenever it is empty or draining.
- Incoming instruction goes to the skid slot only when the output slot is full and not draining.
- dec_ready is registered: next value = !(skid slot valid after this edge).
- Latency: accept at edge N gives ex_valid at N+1 when unstalled. Throughput is 1 per cycle.
- Ordering is strictly FIFO; the skid entry always leaves before any newer instruction.
- Simultaneous accept and drain with both slots full is impossible, since dec_ready = 0 then.
- flush: at the edge, both valid bits clear and the same-cycle accept is dropped; dec_ready = 1 next cycle. flush has priority over all other events.
- rst: same as flush, plus output reset values:
  - ex_valid = 0, ex_reg_write = 0, ex_illegal = 0
  - A = B = 0, ex_rd = 0
  - operation = 100, Binvert = 1, carryin = 0
  - dec_ready = 1 on the first cycle after reset.
- rst or flush mid-stall discards the held instructions; the handshake resumes cleanly.
- Data fields of invalid slots hold their last value.

Optional Feature:
- Macro FORWARD_EN.
- Defined: on entry, if fwd_valid and fwd_rd == dec_rs and fwd_rd != 0, A takes fwd_data. The same rule applies to B when dec_use_imm = 0 and fwd_rd == dec_rt.
- Not defined: fwd_* inputs are ignored; operands come only from dec_* values.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op enum (ADD..XOR, ILLEGAL)
  - ALU control constants OP_ARITH = 100, OP_AND = 000, OP_OR = 001, OP_NOR = 010, OP_XOR = 011
  - width constants DW and RW
- Sub-module alu_ctrl_enc: combinational opcode-to-control encoder, reusable by the ALU testbench.

Test Plan:
- SUB, rs = 0x0005, rt = 0x0003, ex_ready = 1 → next cycle ex_valid = 1, A = 5, B = 3, control 100/0/1, operation stream 1 per cycle.
- XOR with use_imm, imm = 0x00FF → B = 0x00FF, control 011/1/0.
- Hold ex_ready = 0 and issue 3 back-to-back instructions → first in output slot, second in skid slot, dec_ready = 0. Release ex_ready → outputs in order 1, 2, 3 with no loss or duplication.
- flush with both slots full and dec_valid = 1 → next cycle ex_valid = 0, dec_ready = 1, the flushed instructions never appear.
- Opcode 7 → ex_illegal = 1, ex_reg_write = 0, control 100/1/0. Assert rst mid-stream → all reset values next cycle.
- FORWARD_EN, fwd_rd = 2 = dec_rs, fwd_data = 0xBEEF → A = 0xBEEF. With fwd_rd = 0 → A = dec_rs_val.
